acc_scale_quant: RTL and testbench

//  Consumes the 32-bit per-layer scaler produced by the scaler controller and applies it to the

---
 rtl/tnn_acc_pkg.sv | 24 ++
 rtl/acc_scale_quant_pipe.sv | 72 +++++++
 rtl/acc_scale_quant.sv | 156 +++++++++++++++
 tb/tb_acc_scale_quant.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_acc_pkg.sv
// Shared widths and FSM encoding for the accumulator scale/quantize block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tnn_acc_pkg;

   localparam int ACC_W_DEF   = 24;
   localparam int SCL_W_DEF   = 32;
   localparam int FRAC_W_DEF  = 16;
   localparam int OUT_W_DEF   = 8;
   localparam int CNT_W_DEF   = 16;
   localparam int SCL_DLY_DEF = 3;
   localparam int DLY_W       = 4;

   // Layer sequencing states.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4,
      ST_HOLD  = 3'd5
   } fsm_e;

endpackage

// File: rtl/acc_scale_quant_pipe.sv
// Two-stage multiply by fixed-point scaler, then round-half-up and saturate.
// Latency: 2 cycles from in_vld_i to out_vld_o while en_i is high.
// Backpressure: en_i low freezes both stages; flush_i drops all in-flight results.
module scale_mult_pipe #(
   parameter int ACC_W  = 24,
   parameter int SCL_W  = 32,
   parameter int FRAC_W = 16,
   parameter int OUT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en_i,
   input  logic                    flush_i,
   input  logic                    in_vld_i,
   input  logic signed [ACC_W-1:0] acc_dat_i,
   input  logic signed [SCL_W-1:0] scl_i,
   output logic                    out_vld_o,
   output logic signed [OUT_W-1:0] out_dat_o
);

   localparam int PW = ACC_W + SCL_W;
   // One extra bit of headroom so adding the rounding constant cannot wrap.
   localparam logic signed [PW:0] HALF    = (PW+1)'(1) << (FRAC_W - 1);
   localparam logic signed [PW:0] SAT_MAX = (PW+1)'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [PW:0] SAT_MIN = ~SAT_MAX;

   logic                    s1_v_q;
   logic                    s2_v_q;
   logic signed [PW-1:0]    prod_d;
   logic signed [PW-1:0]    prod_q;
   logic signed [PW:0]      rnd_w;
   logic signed [PW:0]      shf_w;
   logic signed [OUT_W-1:0] sat_w;
   logic signed [OUT_W-1:0] dat_q;

   // Both operands sign-extended to the full product width before multiplying.
   assign prod_d = PW'(acc_dat_i) * PW'(scl_i);
   assign rnd_w  = $signed({prod_q[PW-1], prod_q}) + HALF;
   assign shf_w  = rnd_w >>> FRAC_W;

   // Clamp the rounded value into the signed output range.
   always_comb begin
      sat_w = shf_w[OUT_W-1:0];
      if (shf_w > SAT_MAX) begin
         sat_w = SAT_MAX[OUT_W-1:0];
      end else if (shf_w < SAT_MIN) begin
         sat_w = SAT_MIN[OUT_W-1:0];
      end
   end

   // Pipeline registers: flush clears valids, otherwise advance only when enabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
         prod_q <= '0;
         dat_q  <= '0;
      end else if (flush_i) begin
         s1_v_q <= 1'b0;
         s2_v_q <= 1'b0;
      end else if (en_i) begin
         s1_v_q <= in_vld_i;
         prod_q <= prod_d;
         s2_v_q <= s1_v_q;
         dat_q  <= sat_w;
      end
   end

   assign out_vld_o = s2_v_q;
   assign out_dat_o = dat_q;

endmodule

// File: rtl/acc_scale_quant.sv
// Applies the per-layer scaler to accumulator sums and emits saturated activations.
// Latency: accept in cycle N gives out_valid in N+2; one result per cycle.
// Backpressure: out_ready low with a result pending stalls the pipe and drops acc_ready.
module acc_scale_quant
   import tnn_acc_pkg::*;
#(
   parameter int ACC_W   = ACC_W_DEF,
   parameter int SCL_W   = SCL_W_DEF,
   parameter int FRAC_W  = FRAC_W_DEF,
   parameter int OUT_W   = OUT_W_DEF,
   parameter int CNT_W   = CNT_W_DEF,
   parameter int SCL_DLY = SCL_DLY_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    state,
   input  logic signed [SCL_W-1:0] scaler_in,
   input  logic        [CNT_W-1:0] num_elem,
   input  logic                    acc_valid,
   output logic                    acc_ready,
   input  logic signed [ACC_W-1:0] acc_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic                    busy,
   output logic                    done
);

   fsm_e                    fsm_q, fsm_d;
   logic                    state_q;
   logic [CNT_W-1:0]        num_q, num_d;
   logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
   logic [DLY_W-1:0]        dly_q, dly_d;
   logic signed [SCL_W-1:0] scaler_q, scaler_d;
   logic                    en;
   logic                    accept;
   logic                    out_hs;
   logic                    rise;
   logic                    flush;

   assign en        = !out_valid || out_ready;
   assign acc_ready = (fsm_q == ST_RUN) && en && (in_cnt_q < num_q);
   assign accept    = acc_valid && acc_ready;
   assign out_hs    = out_valid && out_ready;
   assign rise      = state && !state_q;
   assign busy      = (fsm_q != ST_IDLE);
   assign done      = (fsm_q == ST_DONE);

   // Next-state and counter logic; dropping state outside IDLE aborts the layer.
   always_comb begin
      fsm_d     = fsm_q;
      num_d     = num_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      dly_d     = dly_q;
      scaler_d  = scaler_q;
      flush     = 1'b0;
      case (fsm_q)
         ST_IDLE: begin
            if (rise) begin
               num_d     = num_elem;
               dly_d     = '0;
               in_cnt_d  = '0;
               out_cnt_d = '0;
               fsm_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Scaler controller needs SCL_DLY (>= 1) cycles after the rise.
            dly_d = dly_q + DLY_W'(1);
            if (dly_q == DLY_W'(SCL_DLY - 1)) begin
               scaler_d = scaler_in;
               fsm_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept) begin
               in_cnt_d = in_cnt_q + CNT_W'(1);
            end
            if (out_hs) begin
               out_cnt_d = out_cnt_q + CNT_W'(1);
            end
            if (in_cnt_d == num_q) begin
               fsm_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (out_hs) begin
               out_cnt_d = out_cnt_q + CNT_W'(1);
            end
            // Counting this cycle's handshake lets done follow the last result directly.
            if (out_cnt_d == num_q) begin
               fsm_d = ST_DONE;
            end
         end
         ST_DONE: begin
            fsm_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!state) begin
               fsm_d = ST_IDLE;
            end
         end
         default: begin
            fsm_d = ST_IDLE;
         end
      endcase
      if ((fsm_q != ST_IDLE) && !state) begin
         fsm_d     = ST_IDLE;
         flush     = 1'b1;
         in_cnt_d  = '0;
         out_cnt_d = '0;
         dly_d     = '0;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q     <= ST_IDLE;
         state_q   <= 1'b0;
         num_q     <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         dly_q     <= '0;
         scaler_q  <= '0;
      end else begin
         fsm_q     <= fsm_d;
         state_q   <= state;
         num_q     <= num_d;
         in_cnt_q  <= in_cnt_d;
         out_cnt_q <= out_cnt_d;
         dly_q     <= dly_d;
         scaler_q  <= scaler_d;
      end
   end

   scale_mult_pipe #(
      .ACC_W  (ACC_W),
      .SCL_W  (SCL_W),
      .FRAC_W (FRAC_W),
      .OUT_W  (OUT_W)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en),
      .flush_i   (flush),
      .in_vld_i  (accept),
      .acc_dat_i (acc_data),
      .scl_i     (scaler_q),
      .out_vld_o (out_valid),
      .out_dat_o (out_data)
   );

endmodule

// File: tb/tb_acc_scale_quant.sv
// Directed bench for acc_scale_quant with a queue-based reference model.
// Latency: checks 2-cycle accept-to-output and done one cycle after the last result.
// Backpressure: exercises an out_ready stall and abort/flush behaviour.
module tb_acc_scale_quant;

   localparam int ACC_W   = 24;
   localparam int SCL_W   = 32;
   localparam int FRAC_W  = 16;
   localparam int OUT_W   = 8;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 200;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    state = 1'b0;
   logic signed [SCL_W-1:0] scaler_in = '0;
   logic        [CNT_W-1:0] num_elem = '0;
   logic                    acc_valid = 1'b0;
   logic                    acc_ready;
   logic signed [ACC_W-1:0] acc_data = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic signed [OUT_W-1:0] out_data;
   logic                    busy;
   logic                    done;

   always #5 clk = ~clk;

   acc_scale_quant #(
      .ACC_W(ACC_W), .SCL_W(SCL_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .SCL_DLY(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .state(state), .scaler_in(scaler_in), .num_elem(num_elem),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_data(acc_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int exp_q[$];
   int acc_cyc_q[$];
   int got_q[$];
   int cur_scl = 0;
   bit chk_lat = 1'b0;
   int done_cnt = 0;
   int done_cyc = -1;
   int last_out_cyc = -1;
   int layer_done0 = 0;
   bit prev_stall = 1'b0;
   int prev_dat = 0;
   int t4_exp[8] = '{-60, -43, -27, -10, 6, 23, 39, 56};

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference rule: product scaled by 2^-FRAC_W, ties rounded up, clamped to OUT_W bits.
   function automatic int quant(input int a, input int s);
      longint p;
      longint r;
      p = longint'(a) * longint'(s);
      r = (p + (64'sd1 <<< (FRAC_W - 1))) >>> FRAC_W;
      if (r > 127) return 127;
      if (r < -128) return -128;
      return int'(r);
   endfunction

   function automatic int got_at(input int i);
      if (i < got_q.size()) return got_q[i];
      return -9999;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Compare process: checks every presented result against the model queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), prev_dat);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_out: got data %0d, required no output (cycle %0d)",
                        out_data, cyc);
            end else begin
               chk("out_data", int'(out_data), exp_q[0]);
               if (out_ready) begin
                  if (chk_lat) chk("latency", cyc - acc_cyc_q[0], 2);
                  void'(exp_q.pop_front());
                  void'(acc_cyc_q.pop_front());
                  got_q.push_back(int'(out_data));
                  last_out_cyc = cyc;
               end
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_dat   = int'(out_data);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (acc_valid && acc_ready) begin
            exp_q.push_back(quant(int'(acc_data), cur_scl));
            acc_cyc_q.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise state; scaler_in only becomes correct 3 cycles later and changes after the latch.
   task automatic start_layer(input int scl, input int n);
      got_q.delete();
      cur_scl     = scl;
      layer_done0 = done_cnt;
      state       = 1'b1;
      num_elem    = CNT_W'(n);
      scaler_in   = 32'h7FFF_FFFF;
      tick();
      num_elem = 16'd99;
      tick();
      tick();
      scaler_in = scl;
      tick();
      scaler_in = 32'h1234_5678;
      chk("run_busy", int'(busy), 1);
   endtask

   task automatic send(input int v);
      int k;
      k = 0;
      acc_valid = 1'b1;
      acc_data  = ACC_W'(v);
      @(negedge clk);
      while (!acc_ready && k < TIMEOUT) begin
         @(negedge clk);
         k++;
      end
      if (k >= TIMEOUT) begin
         n_chk++;
         n_err++;
         $display("FAIL send_timeout: acc_ready got 0, required 1");
      end
      @(posedge clk);
      #1;
      acc_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (done_cnt == layer_done0 && k < TIMEOUT) begin
         tick();
         k++;
      end
      chk("done_seen", done_cnt - layer_done0, 1);
      tick();
      tick();
      chk("done_single", done_cnt - layer_done0, 1);
      chk("hold_busy", int'(busy), 1);
   endtask

   task automatic end_layer();
      state = 1'b0;
      tick();
      chk("idle_busy", int'(busy), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      #12;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_acc_ready", int'(acc_ready), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_out_data", int'(out_data), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      // 1.0 scaler passes values through
      chk_lat = 1'b1;
      start_layer(32'h0001_0000, 3);
      send(5); send(-7); send(0);
      wait_done();
      chk("t1_done_lag", done_cyc - last_out_cyc, 1);
      chk("t1_count", got_q.size(), 3);
      chk("t1_o0", got_at(0), 5);
      chk("t1_o1", got_at(1), -7);
      chk("t1_o2", got_at(2), 0);
      end_layer();

      // 0.5 scaler, ties round toward +inf
      start_layer(32'h0000_8000, 3);
      send(3); send(-3); send(1);
      wait_done();
      chk("t2_o0", got_at(0), 2);
      chk("t2_o1", got_at(1), -1);
      chk("t2_o2", got_at(2), 1);
      end_layer();

      // saturation at both ends, negative scaler
      start_layer(32'h0001_0000, 2);
      send(1000); send(-1000);
      wait_done();
      chk("t3_pos_sat", got_at(0), 127);
      chk("t3_neg_sat", got_at(1), -128);
      end_layer();
      start_layer(32'hFFFF_0000, 1);
      send(200);
      wait_done();
      chk("t3_neg_scl", got_at(0), -128);
      end_layer();
      chk_lat = 1'b0;

      // out_ready stall mid-stream with 1.5 scaler
      start_layer(32'h0001_8000, 8);
      fork
         begin
            for (int i = 0; i < 8; i++) send(i * 11 - 40);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("stall_acc_ready", int'(acc_ready), 0);
               chk("stall_out_valid", int'(out_valid), 1);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      wait_done();
      chk("t4_count", got_q.size(), 8);
      for (int i = 0; i < 8; i++) chk("t4_order", got_at(i), t4_exp[i]);
      end_layer();

      // abort after 2 of 6 accepts, then a fresh layer
      start_layer(32'h0001_0000, 6);
      send(7); send(8);
      state = 1'b0;
      tick();
      exp_q.delete();
      acc_cyc_q.delete();
      chk("abort_out_valid", int'(out_valid), 0);
      chk("abort_busy", int'(busy), 0);
      repeat (4) tick();
      chk("abort_no_done", done_cnt - layer_done0, 0);
      chk("abort_delivered", got_q.size(), 1);
      start_layer(32'h0002_0000, 2);
      send(9); send(-70);
      wait_done();
      chk("t5_o0", got_at(0), 18);
      chk("t5_o1", got_at(1), -128);
      end_layer();

      // empty layer: never ready, still completes
      start_layer(32'h0001_0000, 0);
      acc_valid = 1'b1;
      acc_data  = 24'sd3;
      k = 0;
      while (done_cnt == layer_done0 && k < TIMEOUT) begin
         @(negedge clk);
         chk("zero_acc_ready", int'(acc_ready), 0);
         @(posedge clk);
         #1;
         k++;
      end
      acc_valid = 1'b0;
      wait_done();
      chk("zero_no_out", got_q.size(), 0);
      end_layer();

      // asynchronous reset in the middle of a layer
      start_layer(32'h0001_0000, 4);
      send(1); send(2);
      #3;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      acc_cyc_q.delete();
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_acc_ready", int'(acc_ready), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_done", int'(done), 0);
      chk("arst_out_data", int'(out_data), 0);
      state = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("post_rst_busy", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
